// File: rtl/inst_rom_loader_pkg.sv
// Shared types and constants for the instruction ROM loader.
// The optional checksum output is enabled by `define INST_ROM_CHECKSUM_EN.
package inst_rom_loader_pkg;

  localparam int INST_MEM_NUM_LOG2 = 10;
  localparam int INST_W            = 32;
  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_LOAD  = 2'd1,
    LD_FLUSH = 2'd2,
    LD_RUN   = 2'd3
  } ld_state_e;

  // Big-endian byte placement: lane 0 lands in [31:24], lane 3 in [7:0].
  function automatic logic [INST_W-1:0] place_byte(input logic [INST_W-1:0] word,
                                                   input logic [1:0]        lane,
                                                   input logic [7:0]        data);
    return word | ({24'd0, data} << {~lane, 3'b000});
  endfunction

endpackage

// File: rtl/inst_rom_loader_byte_packer.sv
// Collects loader bytes into big-endian 32-bit words; presents a complete word
// on the 4th accepted byte, or the zero-padded partial word when flushed.
module inst_rom_loader_byte_packer
  import inst_rom_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              accept,
  input  logic              flush,
  input  logic [7:0]        byte_in,
  output logic [INST_W-1:0] word,
  output logic              word_valid,
  output logic              partial
);

  logic [1:0]        cnt_q;
  logic [INST_W-1:0] shift_q;

  always_comb begin
    word       = flush ? shift_q : place_byte(shift_q, cnt_q, byte_in);
    word_valid = flush || (accept && (cnt_q == 2'd3));
    // Byte count as it will be after this cycle's accept.
    partial    = (accept ? (cnt_q + 2'd1) : cnt_q) != 2'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      shift_q <= '0;
    end else if (clr || flush) begin
      cnt_q   <= 2'd0;
      shift_q <= '0;
    end else if (accept) begin
      cnt_q   <= cnt_q + 2'd1;
      shift_q <= (cnt_q == 2'd3) ? '0 : place_byte(shift_q, cnt_q, byte_in);
    end
  end

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction RAM with a byte-serial loader; holds the CPU in reset until a program is loaded.
// `define INST_ROM_CHECKSUM_EN adds ld_csum_o, the wrap-around sum of all words written.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int INST_ADDR_W = INST_MEM_NUM_LOG2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce_i,
  input  logic [31:0]          addr_i,
  output logic [INST_W-1:0]    inst_o,
  output logic                 cpu_rst_o,
  input  logic                 ld_start_i,
  input  logic                 ld_end_i,
  input  logic                 ld_valid_i,
  input  logic [7:0]           ld_data_i,
  output logic                 ld_ready_o,
  output logic [INST_ADDR_W:0] ld_words_o,
  output logic                 ld_ovf_o,
`ifdef INST_ROM_CHECKSUM_EN
  output logic [INST_W-1:0]    ld_csum_o,
`endif
  output ld_state_e            dbg_state
);

  localparam int DEPTH = 1 << INST_ADDR_W;
  localparam logic [INST_ADDR_W:0] FULL_WORDS = {1'b1, {INST_ADDR_W{1'b0}}};
  localparam logic [INST_ADDR_W:0] ONE_WORD   = {{INST_ADDR_W{1'b0}}, 1'b1};

  // Loader handshake: a byte transfers on a rising edge where ld_valid_i && ld_ready_o.
  ld_state_e              state_q, state_d;
  logic [INST_ADDR_W:0]   words_q;
  logic                   ovf_q;
  logic                   crst_q;
  logic                   full;
  logic                   pk_accept, pk_flush, pk_word_valid, pk_partial;
  logic [INST_W-1:0]      pk_word;
  logic [INST_W-1:0]      mem [DEPTH];
  logic                   unused_addr_bits;

  assign full             = (words_q == FULL_WORDS);
  assign ld_words_o       = words_q;
  assign ld_ovf_o         = ovf_q;
  assign dbg_state        = state_q;
  assign unused_addr_bits = ^addr_i[1:0];

  inst_rom_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (ld_start_i),
    .accept     (pk_accept),
    .flush      (pk_flush),
    .byte_in    (ld_data_i),
    .word       (pk_word),
    .word_valid (pk_word_valid),
    .partial    (pk_partial)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LD_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_IDLE:  if (ld_start_i) state_d = LD_LOAD;
      LD_LOAD: begin
        if (ld_start_i)    state_d = LD_LOAD;
        else if (ld_end_i) state_d = pk_partial ? LD_FLUSH : LD_RUN;
      end
      LD_FLUSH: state_d = ld_start_i ? LD_LOAD : LD_RUN;
      LD_RUN:   if (ld_start_i) state_d = LD_LOAD;
      default:  state_d = LD_IDLE;
    endcase
  end

  always_comb begin
    ld_ready_o = (state_q == LD_LOAD) && !ld_start_i && !full;
    pk_accept  = ld_valid_i && ld_ready_o;
    pk_flush   = (state_q == LD_FLUSH) && !ld_start_i;
    // crst_q stretches reset over the first RUN cycle.
    cpu_rst_o  = (state_q != LD_RUN) || crst_q;
    inst_o     = ZERO_WORD;
    if (ce_i && (state_q == LD_RUN) && (addr_i[31:INST_ADDR_W+2] == '0))
      inst_o = mem[addr_i[INST_ADDR_W+1:2]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_q <= '0;
      ovf_q   <= 1'b0;
      crst_q  <= 1'b1;
    end else begin
      crst_q <= (state_q != LD_RUN);
      if (ld_start_i) begin
        words_q <= '0;
        ovf_q   <= 1'b0;
      end else begin
        if (pk_word_valid) words_q <= words_q + ONE_WORD;
        if ((state_q == LD_LOAD) && ld_valid_i && full) ovf_q <= 1'b1;
      end
    end
  end

  // Program RAM survives reset; only the loader ever writes it.
  always_ff @(posedge clk) begin
    if (pk_word_valid) mem[words_q[INST_ADDR_W-1:0]] <= pk_word;
  end

`ifdef INST_ROM_CHECKSUM_EN
  logic [INST_W-1:0] csum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                csum_q <= '0;
    else if (ld_start_i)    csum_q <= '0;
    else if (pk_word_valid) csum_q <= csum_q + pk_word;
  end

  assign ld_csum_o = csum_q;
`endif

endmodule
